// File: rtl/phy_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | phy_rx : 64B/66B receive PHY, Clause 49 block decode to 64-bit AXI-Stream.  |
// | Optional block-lock tracking: define PHY_RX_BLOCK_LOCK_EN.                  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module phy_rx #(
  parameter int P_LOCK_CNT    = 64,
  parameter int P_BAD_HDR_MAX = 16,
  parameter int P_SLIP_WAIT   = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_gt_rxdata,
  input  logic [1:0]  i_gt_rxheader,
  input  logic        i_gt_rxdatavalid,
  input  logic        i_gt_rxheadervalid,
  output logic        o_gt_rxslip,
  output logic        o_block_lock,
  output logic [63:0] m_axis_data,
  output logic [7:0]  m_axis_keep,
  output logic        m_axis_last,
  output logic        m_axis_user,
  output logic        m_axis_valid,
  output logic        o_rx_err
);

  localparam logic [1:0] HDR_DATA  = 2'b01;
  localparam logic [1:0] HDR_CTRL  = 2'b10;
  localparam logic [7:0] TYPE_S0   = 8'h78;
  localparam logic [7:0] TYPE_IDLE = 8'h1E;

  logic hdr_valid;
  assign hdr_valid = (i_gt_rxheader == HDR_DATA) || (i_gt_rxheader == HDR_CTRL);

`ifdef PHY_RX_BLOCK_LOCK_EN
  typedef enum logic [1:0] {
    LK_HUNT   = 2'd0,
    LK_SLIP   = 2'd1,
    LK_LOCKED = 2'd2
  } lock_state_t;

  localparam int GOOD_W = $clog2(P_LOCK_CNT + 1);
  localparam int WAIT_W = $clog2(P_SLIP_WAIT + 1);
  localparam int BAD_W  = $clog2(P_BAD_HDR_MAX + 1);

  lock_state_t       lk_state, lk_next;
  logic [GOOD_W-1:0] good_cnt, good_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [5:0]        win_cnt, win_next;
  logic [BAD_W-1:0]  bad_cnt, bad_next;
  logic              slip_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lk_state    <= LK_HUNT;
      good_cnt    <= '0;
      wait_cnt    <= '0;
      win_cnt     <= '0;
      bad_cnt     <= '0;
      o_gt_rxslip <= 1'b0;
    end else begin
      lk_state    <= lk_next;
      good_cnt    <= good_next;
      wait_cnt    <= wait_next;
      win_cnt     <= win_next;
      bad_cnt     <= bad_next;
      o_gt_rxslip <= slip_next;
    end
  end

  always_comb begin
    lk_next   = lk_state;
    good_next = good_cnt;
    wait_next = wait_cnt;
    win_next  = win_cnt;
    bad_next  = bad_cnt;
    slip_next = 1'b0;
    case (lk_state)
      LK_HUNT: begin
        if (i_gt_rxheadervalid) begin
          if (!hdr_valid) begin
            slip_next = 1'b1;
            good_next = '0;
            wait_next = '0;
            lk_next   = LK_SLIP;
          end else if (good_cnt == GOOD_W'(P_LOCK_CNT - 1)) begin
            good_next = '0;
            win_next  = '0;
            bad_next  = '0;
            lk_next   = LK_LOCKED;
          end else begin
            good_next = good_cnt + 1'b1;
          end
        end
      end
      LK_SLIP: begin
        if (wait_cnt == WAIT_W'(P_SLIP_WAIT - 1)) lk_next = LK_HUNT;
        else wait_next = wait_cnt + 1'b1;
      end
      LK_LOCKED: begin
        // Bad headers are counted per 64-header window; the window restarts clean.
        if (i_gt_rxheadervalid) begin
          if (!hdr_valid && (bad_cnt == BAD_W'(P_BAD_HDR_MAX - 1))) begin
            lk_next   = LK_HUNT;
            good_next = '0;
            win_next  = '0;
            bad_next  = '0;
          end else if (win_cnt == 6'd63) begin
            win_next = '0;
            bad_next = '0;
          end else begin
            win_next = win_cnt + 1'b1;
            if (!hdr_valid) bad_next = bad_cnt + 1'b1;
          end
        end
      end
      default: lk_next = LK_HUNT;
    endcase
  end

  assign o_block_lock = (lk_state == LK_LOCKED);
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_block_lock <= 1'b0;
    else       o_block_lock <= 1'b1;
  end

  assign o_gt_rxslip = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } dec_state_t;

  dec_state_t  state, state_next;
  logic [55:0] residual, residual_next;
  logic        tail_pending, tail_pending_next;
  logic [63:0] tail_data, tail_data_next;
  logic [7:0]  tail_keep, tail_keep_next;
  logic [63:0] data_next;
  logic [7:0]  keep_next;
  logic        last_next, user_next, valid_next, err_next;

  logic [63:0] lanes;
  logic [63:0] tail_mask;
  logic [7:0]  tail_keep_calc;
  logic [7:0]  blk_type;
  logic        accept, is_data, is_ctrl, term_hit;
  logic [2:0]  term_n;

  // Lane 0 (first on the wire) moves to the MSB byte so frames read left to right.
  always_comb begin
    for (int b = 0; b < 8; b++) lanes[63-8*b -: 8] = i_gt_rxdata[8*b +: 8];
  end

  assign blk_type = i_gt_rxdata[7:0];
  assign is_data  = (i_gt_rxheader == HDR_DATA);
  assign is_ctrl  = (i_gt_rxheader == HDR_CTRL);
  assign accept   = i_gt_rxdatavalid & i_gt_rxheadervalid & o_block_lock;

  always_comb begin
    term_hit = 1'b1;
    term_n   = 3'd0;
    case (blk_type)
      8'h87:   term_n = 3'd0;
      8'h99:   term_n = 3'd1;
      8'hAA:   term_n = 3'd2;
      8'hB4:   term_n = 3'd3;
      8'hCC:   term_n = 3'd4;
      8'hD2:   term_n = 3'd5;
      8'hE1:   term_n = 3'd6;
      8'hFF:   term_n = 3'd7;
      default: term_hit = 1'b0;
    endcase
  end

  assign tail_keep_calc = 8'hFF << (4'd9 - {1'b0, term_n});

  always_comb begin
    for (int b = 0; b < 8; b++) tail_mask[8*b +: 8] = {8{tail_keep_calc[b]}};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      residual     <= '0;
      tail_pending <= 1'b0;
      tail_data    <= '0;
      tail_keep    <= '0;
      m_axis_data  <= '0;
      m_axis_keep  <= '0;
      m_axis_last  <= 1'b0;
      m_axis_user  <= 1'b0;
      m_axis_valid <= 1'b0;
      o_rx_err     <= 1'b0;
    end else begin
      state        <= state_next;
      residual     <= residual_next;
      tail_pending <= tail_pending_next;
      tail_data    <= tail_data_next;
      tail_keep    <= tail_keep_next;
      m_axis_data  <= data_next;
      m_axis_keep  <= keep_next;
      m_axis_last  <= last_next;
      m_axis_user  <= user_next;
      m_axis_valid <= valid_next;
      o_rx_err     <= err_next;
    end
  end

  always_comb begin
    state_next        = state;
    residual_next     = residual;
    tail_pending_next = 1'b0;
    tail_data_next    = tail_data;
    tail_keep_next    = tail_keep;
    data_next         = m_axis_data;
    keep_next         = m_axis_keep;
    last_next         = 1'b0;
    user_next         = 1'b0;
    valid_next        = 1'b0;
    err_next          = 1'b0;

    // A tail only exists while IDLE, so it never competes with a frame beat.
    if (tail_pending) begin
      data_next  = tail_data;
      keep_next  = tail_keep;
      last_next  = 1'b1;
      valid_next = 1'b1;
    end

    if ((state == ST_FRAME) && !o_block_lock) begin
      data_next  = {residual, 8'h00};
      keep_next  = 8'hFE;
      last_next  = 1'b1;
      user_next  = 1'b1;
      valid_next = 1'b1;
      state_next = ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (is_ctrl && (blk_type == TYPE_S0)) begin
            residual_next = lanes[55:0];
            state_next    = ST_FRAME;
          end else if (!(is_ctrl && (blk_type == TYPE_IDLE))) begin
            err_next = 1'b1;
          end
        end
        ST_FRAME: begin
          if (is_data) begin
            data_next     = {residual, lanes[63:56]};
            keep_next     = 8'hFF;
            valid_next    = 1'b1;
            residual_next = lanes[55:0];
          end else if (is_ctrl && term_hit) begin
            valid_next = 1'b1;
            state_next = ST_IDLE;
            if (term_n == 3'd0) begin
              data_next = {residual, 8'h00};
              keep_next = 8'hFE;
              last_next = 1'b1;
            end else begin
              data_next = {residual, lanes[55:48]};
              keep_next = 8'hFF;
              last_next = (term_n == 3'd1);
              if (term_n >= 3'd2) begin
                tail_pending_next = 1'b1;
                tail_data_next    = {lanes[47:0], 16'h0000} & tail_mask;
                tail_keep_next    = tail_keep_calc;
              end
            end
          end else begin
            data_next  = {residual, 8'h00};
            keep_next  = 8'hFE;
            last_next  = 1'b1;
            user_next  = 1'b1;
            valid_next = 1'b1;
            err_next   = 1'b1;
            if (is_ctrl && (blk_type == TYPE_S0)) residual_next = lanes[55:0];
            else state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
